// File: rtl/cmp_pipe.sv
// Pipelined compare/overflow unit with valid/ready handshake and sticky overflow.
// Optional saturating overflow counter enabled by CMP_PIPE_OVF_COUNT_EN.
module cmp_pipe #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic [2:0]       out_op,
  input  logic             ovf_clr,
  output logic             ovf_sticky
`ifdef CMP_PIPE_OVF_COUNT_EN
  ,
  output logic [15:0]      ovf_count
`endif
);

  typedef enum logic [2:0] {
    OP_EQ  = 3'b000,
    OP_NE  = 3'b001,
    OP_GTZ = 3'b010,
    OP_LTZ = 3'b011,
    OP_GEZ = 3'b100,
    OP_LEZ = 3'b101,
    OP_ADD = 3'b110,
    OP_SUB = 3'b111
  } op_e;

  logic [WIDTH:0] aExt;
  logic [WIDTH:0] bExt;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           addOvf;
  logic           subOvf;
  logic           aNeg;
  logic           aZero;
  logic           cmpRes;

  assign aExt = {src_a[WIDTH-1], src_a};
  assign bExt = {src_b[WIDTH-1], src_b};
  assign sum  = aExt + bExt;
  assign diff = aExt - bExt;

  // Only the top two bits survive the shift; their XOR is the overflow.
  assign addOvf = ^(sum >> (WIDTH - 1));
  assign subOvf = ^(diff >> (WIDTH - 1));
  assign aNeg   = src_a[WIDTH-1];
  assign aZero  = ~|src_a;

  always_comb begin
    cmpRes = 1'b0;
    case (op)
      OP_EQ:  cmpRes = (src_a == src_b);
      OP_NE:  cmpRes = (src_a != src_b);
      OP_GTZ: cmpRes = ~aNeg & ~aZero;
      OP_LTZ: cmpRes = aNeg;
      OP_GEZ: cmpRes = ~aNeg;
      OP_LEZ: cmpRes = aNeg | aZero;
      OP_ADD: cmpRes = addOvf;
      OP_SUB: cmpRes = subOvf;
      default: cmpRes = 1'b0;
    endcase
  end

  logic [LATENCY-1:0] vld;
  logic [LATENCY-1:0] resQ;
  logic [2:0]         opQ [LATENCY];
  logic               stall;
  logic               outHs;
  logic               setEv;

  assign out_valid = vld[LATENCY-1];
  assign result    = resQ[LATENCY-1];
  assign out_op    = opQ[LATENCY-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~reset & ~stall;
  assign outHs     = out_valid & out_ready;
  assign setEv     = outHs & result & out_op[2] & out_op[1];

  // A stall only exists with a valid head, so every stage simply freezes.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld  <= '0;
      resQ <= '0;
      for (int i = 0; i < LATENCY; i++) opQ[i] <= 3'b000;
    end else if (!stall) begin
      vld[0]  <= in_valid;
      resQ[0] <= cmpRes;
      opQ[0]  <= op;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i]  <= vld[i-1];
        resQ[i] <= resQ[i-1];
        opQ[i]  <= opQ[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_sticky <= 1'b0;
    end else if (setEv) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

`ifdef CMP_PIPE_OVF_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_count <= 16'h0000;
    end else if (ovf_clr) begin
      ovf_count <= setEv ? 16'h0001 : 16'h0000;
    end else if (setEv && ovf_count != 16'hFFFF) begin
      ovf_count <= ovf_count + 16'h0001;
    end
  end
`endif

endmodule
